// File: rtl/ddrx_splitter_pkg.sv
// Shared definitions for the DDRx command burst splitter: FSM state encoding
// and the beat count used when a command arrives with a zero burst length.
package ddrx_splitter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } split_state_t;

  // A burst length of zero is issued as a single-word burst.
  localparam int unsigned ZERO_BURSTLEN_BEATS = 1;

endpackage : ddrx_splitter_pkg

// File: rtl/ddrx_beat_out_reg.sv
// Single-entry registered output slot with valid/ready handshake.
// Loads a new payload whenever the slot is empty or being drained in the same
// cycle, so back-to-back beats flow at full throughput.
module ddrx_beat_out_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 ctl_clk,
  input  logic                 ctl_reset_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic                 load_ok
);

  assign load_ok = ~out_valid | out_ready;

  // Slot register: capture on load, otherwise retire when the consumer takes it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      out_valid   <= 1'b0;
      // NOTE: the payload is reset too (not just valid) because the beat
      // outputs must read zero while in reset.
      payload_out <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      payload_out <= payload_in;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule : ddrx_beat_out_reg

// File: rtl/ddrx_cmd_burst_splitter.sv
// DDRx command burst splitter: turns each accepted burst command into a
// sequence of single-word beats in address order, pairing write beats with
// data taken from the write channel.
// Optional build macro DDRX_SPLIT_ADDR_WRAP_EN: when defined, only the low
// AVL_SIZE_WIDTH address bits advance (wrapping burst); otherwise the full
// address increments linearly and wraps modulo 2^AVL_ADDR_WIDTH.
module ddrx_cmd_burst_splitter
  import ddrx_splitter_pkg::*;
#(
  parameter int AVL_SIZE_WIDTH = 3,
  parameter int AVL_ADDR_WIDTH = 25,
  parameter int AVL_DATA_WIDTH = 32,
  parameter int LOCAL_ID_WIDTH = 8
) (
  input  logic                        ctl_clk,
  input  logic                        ctl_reset_n,
  // Command channel
  input  logic                        itf_cmd_valid,
  output logic                        itf_cmd_ready,
  input  logic                        itf_cmd,
  input  logic [AVL_ADDR_WIDTH-1:0]   itf_cmd_address,
  input  logic [AVL_SIZE_WIDTH-1:0]   itf_cmd_burstlen,
  input  logic [LOCAL_ID_WIDTH-1:0]   itf_cmd_id,
  // Write data channel
  input  logic                        itf_wr_data_valid,
  output logic                        itf_wr_data_ready,
  input  logic [AVL_DATA_WIDTH-1:0]   itf_wr_data,
  input  logic [AVL_DATA_WIDTH/8-1:0] itf_wr_data_byte_en,
  // Beat output channel
  output logic                        beat_valid,
  input  logic                        beat_ready,
  output logic                        beat_write,
  output logic [AVL_ADDR_WIDTH-1:0]   beat_address,
  output logic [AVL_DATA_WIDTH-1:0]   beat_data,
  output logic [AVL_DATA_WIDTH/8-1:0] beat_byte_en,
  output logic [LOCAL_ID_WIDTH-1:0]   beat_id,
  output logic                        beat_first,
  output logic                        beat_last,
  output logic                        busy
);

  localparam int BE_W      = AVL_DATA_WIDTH / 8;
  localparam int PAYLOAD_W = 1 + AVL_ADDR_WIDTH + AVL_DATA_WIDTH + BE_W + LOCAL_ID_WIDTH + 2;

  split_state_t                state;
  logic                        cmd_write;
  logic [AVL_ADDR_WIDTH-1:0]   base_addr;
  logic [LOCAL_ID_WIDTH-1:0]   cmd_id;
  logic [AVL_SIZE_WIDTH-1:0]   remaining;
  logic [AVL_SIZE_WIDTH-1:0]   beat_idx;

  logic                        load_ok;
  logic                        issue;
  logic                        last_beat;
  logic [AVL_ADDR_WIDTH-1:0]   next_addr;
  logic [AVL_DATA_WIDTH-1:0]   next_data;
  logic [BE_W-1:0]             next_be;
  logic [PAYLOAD_W-1:0]        payload_in;
  logic [PAYLOAD_W-1:0]        payload_out;

  assign itf_cmd_ready     = (state == IDLE);
  assign itf_wr_data_ready = (state == BURST) & cmd_write & load_ok;
  assign issue             = (state == BURST) & load_ok & (~cmd_write | itf_wr_data_valid);
  assign last_beat         = (remaining == AVL_SIZE_WIDTH'(1));
  assign busy              = (state != IDLE) | beat_valid;

`ifdef DDRX_SPLIT_ADDR_WRAP_EN
  logic [AVL_SIZE_WIDTH-1:0] wrap_low;
  assign wrap_low  = base_addr[AVL_SIZE_WIDTH-1:0] + beat_idx;
  assign next_addr = {base_addr[AVL_ADDR_WIDTH-1:AVL_SIZE_WIDTH], wrap_low};
`else
  assign next_addr = base_addr + AVL_ADDR_WIDTH'(beat_idx);
`endif

  // Beat payload: write beats carry channel data, read beats carry zeros.
  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    next_data = '0;
    next_be   = '0;
    if (cmd_write) begin
      next_data = itf_wr_data;
      next_be   = itf_wr_data_byte_en;
    end
  end

  assign payload_in = {cmd_write, next_addr, next_data, next_be, cmd_id,
                       (beat_idx == '0), last_beat};

  // Command FSM: latch the command in IDLE, count beats down in BURST.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state     <= IDLE;
      cmd_write <= 1'b0;
      base_addr <= '0;
      cmd_id    <= '0;
      remaining <= '0;
      beat_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (itf_cmd_valid) begin
            cmd_write <= itf_cmd;
            base_addr <= itf_cmd_address;
            cmd_id    <= itf_cmd_id;
            remaining <= (itf_cmd_burstlen == '0) ?
                         AVL_SIZE_WIDTH'(ZERO_BURSTLEN_BEATS) : itf_cmd_burstlen;
            beat_idx  <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            remaining <= remaining - AVL_SIZE_WIDTH'(1);
            beat_idx  <= beat_idx + AVL_SIZE_WIDTH'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ddrx_beat_out_reg #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_beat_out_reg (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .load        (issue),
    .payload_in  (payload_in),
    .out_ready   (beat_ready),
    .out_valid   (beat_valid),
    .payload_out (payload_out),
    .load_ok     (load_ok)
  );

  assign {beat_write, beat_address, beat_data, beat_byte_en, beat_id,
          beat_first, beat_last} = payload_out;

endmodule : ddrx_cmd_burst_splitter

// File: tb/tb_ddrx_cmd_burst_splitter.sv
// Directed testbench for ddrx_cmd_burst_splitter. Expected address sequences
// follow the build: DDRX_SPLIT_ADDR_WRAP_EN selects the wrapping expectations.
module tb_ddrx_cmd_burst_splitter;

  localparam int SW = 3;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int IW = 8;

  logic          ctl_clk = 1'b0;
  logic          ctl_reset_n;
  logic          itf_cmd_valid;
  logic          itf_cmd_ready;
  logic          itf_cmd;
  logic [AW-1:0] itf_cmd_address;
  logic [SW-1:0] itf_cmd_burstlen;
  logic [IW-1:0] itf_cmd_id;
  logic          itf_wr_data_valid;
  logic          itf_wr_data_ready;
  logic [DW-1:0] itf_wr_data;
  logic [3:0]    itf_wr_data_byte_en;
  logic          beat_valid;
  logic          beat_ready;
  logic          beat_write;
  logic [AW-1:0] beat_address;
  logic [DW-1:0] beat_data;
  logic [3:0]    beat_byte_en;
  logic [IW-1:0] beat_id;
  logic          beat_first;
  logic          beat_last;
  logic          busy;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
    logic [IW-1:0] id;
    logic          first;
    logic          last;
  } beat_t;

  beat_t beat_q[$];
  beat_t mon_b;
  int    wr_ready_cnt = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 ctl_clk = ~ctl_clk;

  ddrx_cmd_burst_splitter #(
    .AVL_SIZE_WIDTH (SW),
    .AVL_ADDR_WIDTH (AW),
    .AVL_DATA_WIDTH (DW),
    .LOCAL_ID_WIDTH (IW)
  ) dut (
    .ctl_clk             (ctl_clk),
    .ctl_reset_n         (ctl_reset_n),
    .itf_cmd_valid       (itf_cmd_valid),
    .itf_cmd_ready       (itf_cmd_ready),
    .itf_cmd             (itf_cmd),
    .itf_cmd_address     (itf_cmd_address),
    .itf_cmd_burstlen    (itf_cmd_burstlen),
    .itf_cmd_id          (itf_cmd_id),
    .itf_wr_data_valid   (itf_wr_data_valid),
    .itf_wr_data_ready   (itf_wr_data_ready),
    .itf_wr_data         (itf_wr_data),
    .itf_wr_data_byte_en (itf_wr_data_byte_en),
    .beat_valid          (beat_valid),
    .beat_ready          (beat_ready),
    .beat_write          (beat_write),
    .beat_address        (beat_address),
    .beat_data           (beat_data),
    .beat_byte_en        (beat_byte_en),
    .beat_id             (beat_id),
    .beat_first          (beat_first),
    .beat_last           (beat_last),
    .busy                (busy)
  );

  // Record every completed beat handshake and every wr_data_ready cycle, mid-cycle.
  always @(negedge ctl_clk) begin
    if (itf_wr_data_ready) wr_ready_cnt++;
    if (ctl_reset_n && beat_valid && beat_ready) begin
      mon_b.write = beat_write;
      mon_b.addr  = beat_address;
      mon_b.data  = beat_data;
      mon_b.be    = beat_byte_en;
      mon_b.id    = beat_id;
      mon_b.first = beat_first;
      mon_b.last  = beat_last;
      beat_q.push_back(mon_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  // Present a command and hold it until the cycle in which it is accepted.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                          input logic [SW-1:0] len, input logic [IW-1:0] id);
    int n = 0;
    itf_cmd_valid    = 1'b1;
    itf_cmd          = wr;
    itf_cmd_address  = addr;
    itf_cmd_burstlen = len;
    itf_cmd_id       = id;
    while (!itf_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept_in_time", {63'd0, itf_cmd_ready}, 64'd1);
    tick();
    itf_cmd_valid = 1'b0;
  endtask

  // Offer one write word and hold it until it is consumed.
  task automatic push_wr(input logic [DW-1:0] d, input logic [3:0] be);
    int n = 0;
    itf_wr_data_valid   = 1'b1;
    itf_wr_data         = d;
    itf_wr_data_byte_en = be;
    while (!itf_wr_data_ready && n < 50) begin
      tick();
      n++;
    end
    check("wr_accept_in_time", {63'd0, itf_wr_data_ready}, 64'd1);
    tick();
    itf_wr_data_valid = 1'b0;
  endtask

  // Wait (bounded) for the beat queue to reach n entries, then drain a little
  // longer so duplicated beats would show up in the count.
  task automatic wait_beats(input string tag, input int n);
    int c = 0;
    while (beat_q.size() < n && c < 100) begin
      tick();
      c++;
    end
    repeat (3) tick();
    check(tag, 64'(beat_q.size()), 64'(n));
  endtask

  initial begin
    int b0;
    logic [AW-1:0] exp_wrap [4];

    ctl_reset_n         = 1'b0;
    itf_cmd_valid       = 1'b0;
    itf_cmd             = 1'b0;
    itf_cmd_address     = '0;
    itf_cmd_burstlen    = '0;
    itf_cmd_id          = '0;
    itf_wr_data_valid   = 1'b0;
    itf_wr_data         = '0;
    itf_wr_data_byte_en = '0;
    beat_ready          = 1'b1;
    repeat (3) tick();
    ctl_reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_cmd_ready", {63'd0, itf_cmd_ready}, 64'd1);
    check("rst_beat_valid", {63'd0, beat_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wr_ready", {63'd0, itf_wr_data_ready}, 64'd0);
    check("rst_beat_address", 64'(beat_address), 64'd0);

    // Read burst, addr 0x100, len 4, consumer always ready
    b0 = beat_q.size();
    wr_ready_cnt = 0;
    send_cmd(1'b0, 25'h100, 3'd4, 8'h11);
    check("rd_cmd_ready_low", {63'd0, itf_cmd_ready}, 64'd0);
    check("rd_latency_not_yet", {63'd0, beat_valid}, 64'd0);
    tick();
    check("rd_latency_valid", {63'd0, beat_valid}, 64'd1);
    check("rd_first_addr_live", 64'(beat_address), 64'h100);
    wait_beats("rd_beat_count", b0 + 4);
    for (int i = 0; i < 4; i++) begin
      check("rd_addr", 64'(beat_q[b0+i].addr), 64'h100 + 64'(i));
      check("rd_first", {63'd0, beat_q[b0+i].first}, (i == 0) ? 64'd1 : 64'd0);
      check("rd_last", {63'd0, beat_q[b0+i].last}, (i == 3) ? 64'd1 : 64'd0);
      check("rd_write", {63'd0, beat_q[b0+i].write}, 64'd0);
      check("rd_data_zero", 64'(beat_q[b0+i].data), 64'd0);
      check("rd_id", 64'(beat_q[b0+i].id), 64'h11);
    end
    check("rd_wr_ready_never", 64'(wr_ready_cnt), 64'd0);
    check("rd_back_idle", {63'd0, itf_cmd_ready}, 64'd1);
    check("rd_not_busy", {63'd0, busy}, 64'd0);

    // Write burst, addr 0x20, len 3, gap in write data after the first word
    b0 = beat_q.size();
    send_cmd(1'b1, 25'h20, 3'd3, 8'h22);
    push_wr(32'hA, 4'hF);
    repeat (3) tick();
    check("wr_no_beat_in_gap", 64'(beat_q.size()), 64'(b0 + 1));
    check("wr_busy_in_gap", {63'd0, busy}, 64'd1);
    push_wr(32'hB, 4'h3);
    push_wr(32'hC, 4'hC);
    wait_beats("wr_beat_count", b0 + 3);
    check("wr_data0", 64'(beat_q[b0].data), 64'hA);
    check("wr_data1", 64'(beat_q[b0+1].data), 64'hB);
    check("wr_data2", 64'(beat_q[b0+2].data), 64'hC);
    check("wr_be1", 64'(beat_q[b0+1].be), 64'h3);
    check("wr_be2", 64'(beat_q[b0+2].be), 64'hC);
    for (int i = 0; i < 3; i++) begin
      check("wr_addr", 64'(beat_q[b0+i].addr), 64'h20 + 64'(i));
      check("wr_write", {63'd0, beat_q[b0+i].write}, 64'd1);
      check("wr_id", 64'(beat_q[b0+i].id), 64'h22);
    end
    check("wr_first", {63'd0, beat_q[b0].first}, 64'd1);
    check("wr_last", {63'd0, beat_q[b0+2].last}, 64'd1);

    // Read, len 2, consumer stalls on beat 0 for 5 cycles
    b0 = beat_q.size();
    beat_ready = 1'b0;
    send_cmd(1'b0, 25'h300, 3'd2, 8'h33);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'd0, beat_valid}, 64'd1);
      check("stall_addr", 64'(beat_address), 64'h300);
      check("stall_first", {63'd0, beat_first}, 64'd1);
      check("stall_last", {63'd0, beat_last}, 64'd0);
      check("stall_id", 64'(beat_id), 64'h33);
      tick();
    end
    beat_ready = 1'b1;
    wait_beats("stall_beat_count", b0 + 2);
    check("stall_addr0", 64'(beat_q[b0].addr), 64'h300);
    check("stall_addr1", 64'(beat_q[b0+1].addr), 64'h301);
    check("stall_first0", {63'd0, beat_q[b0].first}, 64'd1);
    check("stall_last1", {63'd0, beat_q[b0+1].last}, 64'd1);

    // Address rollover at the top of the address space
`ifdef DDRX_SPLIT_ADDR_WRAP_EN
    exp_wrap = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h1FFFFF8, 25'h1FFFFF9};
`else
    exp_wrap = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
`endif
    b0 = beat_q.size();
    send_cmd(1'b0, 25'h1FFFFFE, 3'd4, 8'h44);
    wait_beats("wrap_beat_count", b0 + 4);
    for (int i = 0; i < 4; i++)
      check("wrap_addr", 64'(beat_q[b0+i].addr), 64'(exp_wrap[i]));

    // Burst length zero is one beat
    b0 = beat_q.size();
    send_cmd(1'b0, 25'h7, 3'd0, 8'h55);
    wait_beats("len0_beat_count", b0 + 1);
    check("len0_addr", 64'(beat_q[b0].addr), 64'h7);
    check("len0_first", {63'd0, beat_q[b0].first}, 64'd1);
    check("len0_last", {63'd0, beat_q[b0].last}, 64'd1);

    // Reset in the middle of a len-4 write, right after beat 1 issues
    send_cmd(1'b1, 25'h40, 3'd4, 8'h66);
    push_wr(32'h1111, 4'hF);
    push_wr(32'h2222, 4'hF);
    check("mid_beat1_valid", {63'd0, beat_valid}, 64'd1);
    ctl_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, beat_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_addr", 64'(beat_address), 64'd0);
    check("mid_rst_data", 64'(beat_data), 64'd0);
    tick();
    ctl_reset_n = 1'b1;
    b0 = beat_q.size();
    repeat (3) tick();
    check("post_rst_cmd_ready", {63'd0, itf_cmd_ready}, 64'd1);
    check("post_rst_no_beat", 64'(beat_q.size()), 64'(b0));
    send_cmd(1'b0, 25'h55, 3'd1, 8'h77);
    wait_beats("post_rst_beat_count", b0 + 1);
    check("post_rst_first", {63'd0, beat_q[b0].first}, 64'd1);
    check("post_rst_last", {63'd0, beat_q[b0].last}, 64'd1);
    check("post_rst_addr", 64'(beat_q[b0].addr), 64'h55);
    check("post_rst_id", 64'(beat_q[b0].id), 64'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ddrx_cmd_burst_splitter

// File: doc/ddrx_cmd_burst_splitter.md
DDRX_CMD_BURST_SPLITTER -- requirements
Module: ddrx_cmd_burst_splitter

Interface
REQ-001 SHALL have parameter AVL_SIZE_WIDTH, default 3, burst-length field width.
REQ-002 SHALL have parameter AVL_ADDR_WIDTH, default 25, word address width.
REQ-003 SHALL have parameter AVL_DATA_WIDTH, default 32, data width; byte-enable width = AVL_DATA_WIDTH/8.
REQ-004 SHALL have parameter LOCAL_ID_WIDTH, default 8, command id width.
REQ-005 SHALL have ports, clock and reset first: ctl_clk in 1, controller clock; ctl_reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have command ports: itf_cmd_valid in 1; itf_cmd_ready out 1; itf_cmd in 1 (1=write); itf_cmd_address in AVL_ADDR_WIDTH; itf_cmd_burstlen in AVL_SIZE_WIDTH; itf_cmd_id in LOCAL_ID_WIDTH.
REQ-007 SHALL have write data ports: itf_wr_data_valid in 1; itf_wr_data_ready out 1; itf_wr_data in AVL_DATA_WIDTH; itf_wr_data_byte_en in AVL_DATA_WIDTH/8.
REQ-008 SHALL have beat output ports: beat_valid out 1; beat_ready in 1; beat_write out 1; beat_address out AVL_ADDR_WIDTH; beat_data out AVL_DATA_WIDTH; beat_byte_en out AVL_DATA_WIDTH/8; beat_id out LOCAL_ID_WIDTH; beat_first out 1; beat_last out 1; busy out 1 (state != IDLE or beat_valid).

Function
REQ-009 SHALL split each accepted burst command into one single-word beat per burst word, in address order.
REQ-010 SHALL implement states IDLE and BURST; itf_cmd_ready = (state == IDLE).
REQ-011 SHALL, on itf_cmd_valid & itf_cmd_ready, latch write flag, address, id and remaining = burstlen (burstlen 0 treated as 1), then enter BURST.
REQ-012 SHALL define load_ok = ~beat_valid | beat_ready (single registered output slot, full throughput).
REQ-013 SHALL, in BURST, issue a beat when load_ok & (read | itf_wr_data_valid); itf_wr_data_ready = (state == BURST) & write & load_ok.
REQ-014 SHALL hold itf_wr_data_ready low in IDLE and throughout read bursts; write data is never consumed early.
REQ-015 SHALL register all beat_* outputs; first beat valid two cycles after command acceptance when unstalled.
REQ-016 SHALL hold all beat_* outputs stable while beat_valid & ~beat_ready.
REQ-017 SHALL set beat_first on beat 0 and beat_last on the final beat; both set for 1-word bursts.
REQ-018 SHALL drive beat_address = base + beat index, modulo 2^AVL_ADDR_WIDTH (wraps from all-ones to zero).
REQ-019 SHALL drive beat_data/beat_byte_en from the write channel on write beats and zero on read beats.
REQ-020 SHALL return to IDLE in the cycle after the last beat issues; the next command is accepted no earlier than that IDLE cycle.

Reset
REQ-021 SHALL on ctl_reset_n low asynchronously force state IDLE, remaining 0, beat_valid 0, all beat_* data outputs 0, busy 0.
REQ-022 SHALL discard any partially issued burst on reset mid-operation; no beat issues until a new command is accepted.

Configuration
REQ-023 SHALL, with DDRX_SPLIT_ADDR_WRAP_EN defined, wrap only the low AVL_SIZE_WIDTH address bits (upper bits fixed to base) for wrapping bursts.
REQ-024 SHALL, without DDRX_SPLIT_ADDR_WRAP_EN, use linear increment per REQ-018.

Structure
REQ-025 SHALL place the state enum (IDLE, BURST) and the burstlen-zero-to-one conversion constant in shared package ddrx_splitter_pkg.
REQ-026 SHALL implement the registered output slot as sub-module ddrx_beat_out_reg (valid/ready register, load_ok output); no other sub-modules.

Verification
REQ-027 SHALL cover: read, addr 0x100, len 4, beat_ready=1 -> addresses 0x100..0x103, first on beat 0, last on beat 3, wr_data_ready never high.
REQ-028 SHALL cover: write, addr 0x20, len 3, data 0xA,0xB,0xC with valid gap after 0xA -> beats carry 0xA,0xB,0xC in order, no beat during gap.
REQ-029 SHALL cover: read, len 2, beat_ready low 5 cycles on beat 0 -> beat 0 outputs held stable, beat 1 follows, no beat lost or duplicated.
REQ-030 SHALL cover: addr 0x1FFFFFE, len 4 -> linear build: 0x1FFFFFE,0x1FFFFFF,0x0,0x1; wrap build: 0x1FFFFFE,0x1FFFFFF,0x1FFFFF8,0x1FFFFF9.
REQ-031 SHALL cover: burstlen 0 -> exactly one beat with first=last=1.
REQ-032 SHALL cover: reset asserted after beat 1 of len-4 write -> beat_valid 0 immediately, cmd_ready 1 after release, next command starts with beat_first=1.
